// File: rtl/multi_alarm_clock_pkg.sv
// multi_alarm_clock_pkg: shared BCD types, FSM states and time helpers for the alarm clock
package multi_alarm_clock_pkg;
   typedef logic [3:0] bcd_t;
   typedef struct packed {
      logic [1:0] h1;
      bcd_t       h0;
      bcd_t       m1;
      bcd_t       m0;
   } hhmm_t;
   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;
   localparam int SEC_PER_MIN = 60;
   function automatic logic hhmm_valid(hhmm_t t);
      return t.h0 <= 4'd9 && t.m1 <= 4'd5 && t.m0 <= 4'd9 &&
             (t.h1 < 2'd2 || (t.h1 == 2'd2 && t.h0 <= 4'd3));
   endfunction
   function automatic hhmm_t hhmm_inc(hhmm_t t);
      hhmm_t r;
      r = t;
      if (t.m0 != 4'd9) r.m0 = t.m0 + 4'd1;
      else begin
         r.m0 = '0;
         if (t.m1 != 4'd5) r.m1 = t.m1 + 4'd1;
         else begin
            r.m1 = '0;
            if (t.h1 == 2'd2 && t.h0 == 4'd3) begin
               r.h1 = '0;
               r.h0 = '0;
            end else if (t.h0 == 4'd9) begin
               r.h1 = t.h1 + 2'd1;
               r.h0 = '0;
            end else r.h0 = t.h0 + 4'd1;
         end
      end
      return r;
   endfunction
endpackage

// File: rtl/multi_alarm_clock_bcd_time_counter.sv
// bcd_time_counter: 24-hour hh:mm:ss BCD time of day with load and one-second tick
module bcd_time_counter
   import multi_alarm_clock_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  ld,
   input  logic  tick,
   input  hhmm_t ld_val,
   output hhmm_t hm,
   output hhmm_t hm_inc,
   output bcd_t  s1,
   output bcd_t  s0,
   output logic  min_wrap
);
   assign min_wrap = s1 == 4'd5 && s0 == 4'd9;
   assign hm_inc = hhmm_inc(hm);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         hm <= '0;
         s1 <= '0;
         s0 <= '0;
      end else if (ld) begin
         hm <= ld_val;
         s1 <= '0;
         s0 <= '0;
      end else if (tick) begin
         s0 <= s0 == 4'd9 ? 4'd0 : s0 + 4'd1;
         s1 <= s0 != 4'd9 ? s1 : min_wrap ? 4'd0 : s1 + 4'd1;
         if (min_wrap) hm <= hm_inc;
      end
endmodule

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: BCD 24-hour clock with NUM_ALARMS alarm slots and a ring/snooze controller
module multi_alarm_clock
   import multi_alarm_clock_pkg::*;
#(
   parameter  int NUM_ALARMS    = 4,
   parameter  int TICKS_PER_SEC = 1,
   parameter  int SNOOZE_MIN    = 5,
   parameter  int RING_SEC      = 60,
   localparam int AW = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1,
   localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            H_in1,
   input  logic [3:0]            H_in0,
   input  logic [3:0]            M_in1,
   input  logic [3:0]            M_in0,
   input  logic                  LD_time,
   input  logic                  LD_alarm,
   input  logic [AW-1:0]         al_sel,
   input  logic [NUM_ALARMS-1:0] AL_EN,
   input  logic                  STOP_al,
   input  logic                  SNOOZE,
   output logic                  Alarm,
   output logic [AW-1:0]         alarm_id,
   output logic [1:0]            H_out1,
   output logic [3:0]            H_out0,
   output logic [3:0]            M_out1,
   output logic [3:0]            M_out0,
   output logic [3:0]            S_out1,
   output logic [3:0]            S_out0,
   output logic                  load_err
);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0]    RING_LAST = 8'(RING_SEC - 1);
   localparam logic [11:0]   SNZ_LAST  = 12'(SNOOZE_MIN * SEC_PER_MIN - 1);
   hhmm_t ld_hm, hm, hm_inc;
   hhmm_t slot [NUM_ALARMS];
   logic [PW-1:0] pre;
   logic in_ok, t_ok, a_ok, sec_tick, min_wrap, hit;
   logic [AW-1:0] hit_id, id_nxt;
   state_t state, state_nxt;
   logic [7:0] ring_cnt, ring_nxt;
   logic [11:0] snz_cnt, snz_nxt;
   assign ld_hm = '{h1: H_in1, h0: H_in0, m1: M_in1, m0: M_in0};
   assign in_ok = hhmm_valid(ld_hm);
   assign t_ok = LD_time && in_ok;
   assign a_ok = LD_alarm && in_ok && 32'(al_sel) < NUM_ALARMS;
   assign sec_tick = !t_ok && pre == PRE_LAST;
   assign {H_out1, H_out0, M_out1, M_out0} = hm;
   assign Alarm = state == RINGING;
   bcd_time_counter u_cnt (
      .clk      (clk),
      .reset    (reset),
      .ld       (t_ok),
      .tick     (sec_tick),
      .ld_val   (ld_hm),
      .hm       (hm),
      .hm_inc   (hm_inc),
      .s1       (S_out1),
      .s0       (S_out0),
      .min_wrap (min_wrap)
   );
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         pre <= '0;
         load_err <= 1'b0;
         for (int i = 0; i < NUM_ALARMS; i++) slot[i] <= '0;
      end else begin
         pre <= (t_ok || sec_tick) ? '0 : pre + 1'b1;
         load_err <= (LD_time && !in_ok) || (LD_alarm && !a_ok);
         if (a_ok) slot[al_sel] <= ld_hm;
      end
   // a slot matches only on the tick that rolls seconds to 00; scanning downward leaves the lowest index
   always_comb begin
      hit = 1'b0;
      hit_id = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--)
         if (sec_tick && min_wrap && AL_EN[i] && slot[i] == hm_inc) begin
            hit = 1'b1;
            hit_id = AW'(i);
         end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         alarm_id <= '0;
         ring_cnt <= '0;
         snz_cnt <= '0;
      end else begin
         state <= state_nxt;
         alarm_id <= id_nxt;
         ring_cnt <= ring_nxt;
         snz_cnt <= snz_nxt;
      end
   always_comb begin
      state_nxt = state;
      id_nxt = alarm_id;
      ring_nxt = ring_cnt;
      snz_nxt = snz_cnt;
      case (state)
         IDLE:
            if (hit) begin
               state_nxt = RINGING;
               id_nxt = hit_id;
               ring_nxt = '0;
            end
         RINGING:
            if (STOP_al || !AL_EN[alarm_id] || (sec_tick && ring_cnt == RING_LAST)) state_nxt = IDLE;
            else if (SNOOZE) begin
               state_nxt = SNOOZED;
               snz_nxt = '0;
            end else if (sec_tick) ring_nxt = ring_cnt + 8'd1;
         SNOOZED:
            if (STOP_al || !AL_EN[alarm_id]) state_nxt = IDLE;
            else if (sec_tick && snz_cnt == SNZ_LAST) begin
               state_nxt = RINGING;
               ring_nxt = '0;
            end else if (sec_tick) snz_nxt = snz_cnt + 12'd1;
         default: state_nxt = IDLE;
      endcase
   end
endmodule
